// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e    : arbiter FSM state encoding
//   tmo_cnt_width  : width of a counter that must hold 0..timeout inclusive
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_e;

  function automatic int tmo_cnt_width(input int timeout);
    if (timeout < 1) begin
      return 1;
    end else begin
      return $clog2(timeout + 1);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at (i_last+1) mod NUM_REQ and wraps, so the requester
// that was served last has the lowest priority.
//   i_req   : request vector
//   i_last  : index of the requester served last
//   o_grant : index of the winning requester (0 when none)
//   o_valid : at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_valid
);

  localparam int SW = IDX_W + 1;

  // last+offset never exceeds 2*NUM_REQ-1, which fits in IDX_W+1 bits
  logic [SW-1:0]    w_sum;
  logic [IDX_W-1:0] w_idx;

  // Walk offsets 1..NUM_REQ from the last winner; the first live request wins
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_sum = {1'b0, i_last} + SW'(off);
      if (w_sum >= SW'(NUM_REQ)) begin
        w_sum = w_sum - SW'(NUM_REQ);
      end else begin
        w_sum = w_sum;
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!o_valid && i_req[w_idx]) begin
        o_valid = 1'b1;
        o_grant = w_idx;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Minimal 8N1 UART transmitter driven by the arbiter.
//   uart_wr_i  : accept uart_dat_i when idle
//   uart_busy  : high for the whole frame (start, 8 data, stop)
//   uart_tx    : serial line, idle high, LSB first
// Each bit lasts SYS_CLK_RATE/BAUD_RATE clock cycles.
module uart_tx #(
  parameter int BAUD_RATE    = 1,
  parameter int SYS_CLK_RATE = 2
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       uart_wr_i,
  input  logic [7:0] uart_dat_i,
  output logic       uart_busy,
  output logic       uart_tx
);

  localparam int DIV = (SYS_CLK_RATE / BAUD_RATE < 1) ? 1 : SYS_CLK_RATE / BAUD_RATE;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic          r_busy;
  logic          r_line;
  logic [8:0]    r_shift;
  logic [3:0]    r_bits;
  logic [DW-1:0] r_div;

  // Frame shifter: start bit goes out immediately, then data and stop bits
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_busy  <= 1'b0;
      r_line  <= 1'b1;
      r_shift <= 9'h1FF;
      r_bits  <= 4'd0;
      r_div   <= '0;
    end else if (!r_busy) begin
      if (uart_wr_i) begin
        r_busy  <= 1'b1;
        r_line  <= 1'b0;
        r_shift <= {1'b1, uart_dat_i};
        r_bits  <= 4'd9;
        r_div   <= '0;
      end else begin
        r_line  <= 1'b1;
      end
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      if (r_bits == 4'd0) begin
        r_busy <= 1'b0;
        r_line <= 1'b1;
      end else begin
        r_line  <= r_shift[0];
        r_shift <= {1'b1, r_shift[8:1]};
        r_bits  <= r_bits - 4'd1;
      end
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  assign uart_busy = r_busy;
  assign uart_tx   = r_line;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
//   sys_clk_i / sys_rst_i : clock, async active-low reset
//   req_i / dat_i         : per-requester request and byte (byte k at [8k+7:8k])
//   ack_o                 : one-cycle pulse when requester k's byte is written
//   uart_wr_o/uart_dat_o  : write strobe and byte to the transmitter
//   uart_busy_i           : transmitter busy
//   grant_o               : requester currently owning the transmitter
//   err_o                 : one-cycle pulse when busy never rose after a write
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 8,
  parameter int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*8-1:0] dat_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic                 uart_wr_o,
  output logic [7:0]           uart_dat_o,
  input  logic                 uart_busy_i,
  output logic [GW-1:0]        grant_o,
  output logic                 err_o
);

  localparam int CW = tmo_cnt_width(START_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(START_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ACK_ONE = NUM_REQ'(1);

  arb_state_e         r_state, w_state_nxt;
  logic               r_wr, w_wr_nxt;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic [7:0]         r_dat, w_dat_nxt;
  logic [GW-1:0]      r_grant, w_grant_nxt;
  logic [GW-1:0]      r_last, w_last_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic               r_err, w_err_nxt;

  logic [GW-1:0]      w_arb_grant;
  logic               w_arb_valid;
  logic [7:0]         w_arb_byte;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_rr (
    .i_req   (req_i),
    .i_last  (r_last),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_valid)
  );

  assign w_arb_byte = dat_i[{w_arb_grant, 3'b000} +: 8];

  // State and output registers; outputs are computed one cycle ahead
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_state <= ST_IDLE;
      r_wr    <= 1'b0;
      r_ack   <= '0;
      r_dat   <= 8'h00;
      r_grant <= '0;
      r_last  <= GW'(NUM_REQ - 1);
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr    <= w_wr_nxt;
      r_ack   <= w_ack_nxt;
      r_dat   <= w_dat_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = 1'b0;
    w_ack_nxt   = '0;
    w_err_nxt   = 1'b0;
    w_dat_nxt   = r_dat;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        // busy here may come from another source sharing the transmitter
        if (!uart_busy_i && w_arb_valid) begin
          w_state_nxt = ST_ISSUE;
          w_wr_nxt    = 1'b1;
          w_ack_nxt   = ACK_ONE << w_arb_grant;
          w_dat_nxt   = w_arb_byte;
          w_grant_nxt = w_arb_grant;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // the ISSUE cycle counts as the first cycle of the start window, so
        // err_o lands exactly START_TIMEOUT cycles after uart_wr_o
        w_state_nxt = ST_WAIT_START;
        w_cnt_nxt   = CW'(1);
      end
      ST_WAIT_START: begin
        if (uart_busy_i) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_cnt >= CNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt   = (r_cnt < CNT_MAX) ? r_cnt + CW'(1) : r_cnt;
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_busy_i) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_grant;
        end else begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ack_o      = r_ack;
  assign uart_wr_o  = r_wr;
  assign uart_dat_o = r_dat;
  assign grant_o    = r_grant;
  assign err_o      = r_err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb driving a real uart_tx (or a busy stub).
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] dat = 32'h0;
  logic [3:0]  ack;
  logic        wr;
  logic [7:0]  udat;
  logic [1:0]  grant;
  logic        err;
  logic        busy_arb, tx_busy, tx_line, tx_wr;
  logic        stub_en = 1'b0;
  logic        stub_busy = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fall_cyc = 0;
  logic prev_busy;

  logic [7:0] exp_byte_q[$];
  logic [3:0] exp_ack_q[$];
  logic [7:0] rx_q[$];
  logic       rx_active = 1'b0;
  int         rx_phase = 0;
  logic [7:0] rx_shift = 8'h00;

  assign tx_wr    = wr & ~stub_en;
  assign busy_arb = stub_en ? stub_busy : tx_busy;

  uart_tx_arb #(.NUM_REQ(4), .START_TIMEOUT(8)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst_n), .req_i(req), .dat_i(dat),
    .ack_o(ack), .uart_wr_o(wr), .uart_dat_o(udat), .uart_busy_i(busy_arb),
    .grant_o(grant), .err_o(err)
  );

  uart_tx #(.BAUD_RATE(1), .SYS_CLK_RATE(2)) u_tx (
    .sys_clk_i(clk), .sys_rst_i(rst_n), .uart_wr_i(tx_wr), .uart_dat_i(udat),
    .uart_busy(tx_busy), .uart_tx(tx_line)
  );

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // record the cycle in which busy (as seen by the arbiter) fell
  always @(negedge clk) begin
    prev_busy <= busy_arb;
    if (prev_busy === 1'b1 && busy_arb === 1'b0) fall_cyc <= cyc;
  end

  // serial decoder: 2 cycles per bit, sample second cycle of each data bit
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_active <= 1'b0;
    end else if (!rx_active) begin
      if (tx_line === 1'b0) begin
        rx_active <= 1'b1;
        rx_phase  <= 1;
      end
    end else begin
      if (rx_phase >= 3 && rx_phase <= 17 && rx_phase[0]) rx_shift[(rx_phase - 3) / 2] <= tx_line;
      if (rx_phase == 19) begin
        rx_q.push_back(rx_shift);
        rx_active <= 1'b0;
      end
      rx_phase <= rx_phase + 1;
    end
  end

  task automatic wait_wr(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    logic [7:0] e;
    req = 4'b1111;
    dat = {8'h44, 8'h33, 8'h22, 8'h11};
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", wr); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    checks++; if (udat !== 8'h00) begin failures++; $display("FAIL reset_dat got=%h exp=00", udat); end
    checks++; if (grant !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    rx_q.delete();
    exp_byte_q.push_back(8'h11);
    rst_n = 1'b1;
    wait_wr(10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL reset_first_wr got=timeout exp=wr"); end
    checks++; if (grant !== 2'd0) begin failures++; $display("FAIL reset_first_grant got=%0d exp=0", grant); end
    checks++; if (udat !== 8'h11) begin failures++; $display("FAIL reset_first_dat got=%h exp=11", udat); end
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL reset_first_ack got=%b exp=0001", ack); end
    req = 4'b0000;
    wait_rx(1, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL reset_rx got=timeout exp=byte"); end
    while (rx_q.size() > 0 && exp_byte_q.size() > 0) begin
      e = exp_byte_q.pop_front();
      checks++; if (rx_q[0] !== e) begin failures++; $display("FAIL reset_rx_byte got=%h exp=%h", rx_q[0], e); end
      void'(rx_q.pop_front());
    end
    exp_byte_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_fairness();
    bit ok;
    logic [7:0] e;
    logic [3:0] ea;
    rx_q.delete();
    exp_byte_q = '{8'hAA, 8'h55, 8'hAA, 8'h55};
    exp_ack_q  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    dat = {8'h55, 8'h00, 8'hAA, 8'h00};
    req = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      wait_wr(60, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL fair_wr%0d got=timeout exp=wr", n);
      end else begin
        ea = exp_ack_q.pop_front();
        if (ack !== ea) begin failures++; $display("FAIL fair_ack%0d got=%b exp=%b", n, ack, ea); end
      end
      if (n == 3) req = 4'b0000;
    end
    req = 4'b0000;
    wait_rx(4, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL fair_rx got=%0d bytes exp=4", rx_q.size()); end
    while (rx_q.size() > 0 && exp_byte_q.size() > 0) begin
      e = exp_byte_q.pop_front();
      checks++; if (rx_q[0] !== e) begin failures++; $display("FAIL fair_rx_byte got=%h exp=%h", rx_q[0], e); end
      void'(rx_q.pop_front());
    end
    exp_byte_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_lone();
    bit ok;
    logic [7:0] e;
    rx_q.delete();
    dat = {8'h00, 8'h5A, 8'h00, 8'h00};
    req = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      exp_byte_q.push_back(8'h5A);
      wait_wr(60, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL lone_wr%0d got=timeout exp=wr", n);
      end else if (ack !== 4'b0100) begin
        failures++; $display("FAIL lone_ack%0d got=%b exp=0100", n, ack);
      end
      if (n > 0) begin
        checks++; if (cyc - fall_cyc != 2) begin failures++; $display("FAIL lone_gap%0d got=%0d exp=2", n, cyc - fall_cyc); end
      end
      if (n == 2) req = 4'b0000;
    end
    req = 4'b0000;
    wait_rx(3, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL lone_rx got=%0d bytes exp=3", rx_q.size()); end
    while (rx_q.size() > 0 && exp_byte_q.size() > 0) begin
      e = exp_byte_q.pop_front();
      checks++; if (rx_q[0] !== e) begin failures++; $display("FAIL lone_rx_byte got=%h exp=%h", rx_q[0], e); end
      void'(rx_q.pop_front());
    end
    exp_byte_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int t_wr, t_err, nwr;
    stub_en = 1'b1;
    stub_busy = 1'b0;
    dat = {8'h00, 8'h00, 8'h00, 8'h77};
    req = 4'b0001;
    wait_wr(10, ok);
    t_wr = cyc;
    req = 4'b0000;
    checks++; if (!ok) begin failures++; $display("FAIL tmo_wr got=timeout exp=wr"); end
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL tmo_ack got=%b exp=0001", ack); end
    ok = 1'b0;
    t_err = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin ok = 1'b1; t_err = cyc; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL tmo_err got=none exp=pulse"); end
    checks++; if (t_err - t_wr != 8) begin failures++; $display("FAIL tmo_err_delay got=%0d exp=8", t_err - t_wr); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmo_err_width got=%b exp=0", err); end
    nwr = 0;
    repeat (4) begin @(negedge clk); if (wr === 1'b1) nwr++; end
    checks++; if (nwr != 0) begin failures++; $display("FAIL tmo_no_retry got=%0d exp=0", nwr); end
    // back in IDLE: a fresh request is granted at once
    req = 4'b0010;
    wait_wr(3, ok);
    req = 4'b0000;
    checks++; if (!ok || ack !== 4'b0010) begin failures++; $display("FAIL tmo_idle got=%b exp=0010", ack); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (err === 1'b1) break;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ext_busy();
    bit ok;
    int nwr, t_fall;
    stub_en = 1'b1;
    stub_busy = 1'b1;
    dat = {8'h00, 8'h00, 8'h00, 8'h3C};
    req = 4'b0001;
    nwr = 0;
    repeat (10) begin @(negedge clk); if (wr === 1'b1) nwr++; end
    checks++; if (nwr != 0) begin failures++; $display("FAIL ext_hold got=%0d wr exp=0", nwr); end
    stub_busy = 1'b0;
    t_fall = cyc;
    wait_wr(5, ok);
    checks++; if (!ok || cyc - t_fall < 1 || cyc - t_fall > 2) begin failures++; $display("FAIL ext_delay got=%0d exp=1..2", cyc - t_fall); end
    checks++; if (grant !== 2'd0) begin failures++; $display("FAIL ext_grant got=%0d exp=0", grant); end
    checks++; if (udat !== 8'h3C) begin failures++; $display("FAIL ext_dat got=%h exp=3c", udat); end
    req = 4'b0000;
    stub_busy = 1'b1;
    repeat (3) @(negedge clk);
    stub_busy = 1'b0;
    repeat (3) @(negedge clk);
    stub_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] e;
    int nack;
    rx_q.delete();
    dat = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    wait_wr(10, ok);
    checks++; if (!ok || grant !== 2'd1) begin failures++; $display("FAIL mid_grant got=%0d exp=1", grant); end
    checks++; if (udat !== 8'h22) begin failures++; $display("FAIL mid_dat got=%h exp=22", udat); end
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    nack = 0;
    repeat (2) begin @(negedge clk); if (ack !== 4'b0000) nack++; end
    checks++; if (nack != 0) begin failures++; $display("FAIL mid_no_ack got=%0d exp=0", nack); end
    checks++; if (wr !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL mid_rst_out got=%b%b exp=00", wr, err); end
    checks++; if (grant !== 2'd0 || udat !== 8'h00) begin failures++; $display("FAIL mid_rst_regs got=%0d/%h exp=0/00", grant, udat); end
    rx_q.delete();
    exp_byte_q.push_back(8'h11);
    rst_n = 1'b1;
    wait_wr(10, ok);
    checks++; if (!ok || grant !== 2'd0) begin failures++; $display("FAIL mid_next_grant got=%0d exp=0", grant); end
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL mid_next_ack got=%b exp=0001", ack); end
    req = 4'b0000;
    wait_rx(1, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_rx got=timeout exp=byte"); end
    while (rx_q.size() > 0 && exp_byte_q.size() > 0) begin
      e = exp_byte_q.pop_front();
      checks++; if (rx_q[0] !== e) begin failures++; $display("FAIL mid_rx_byte got=%h exp=%h", rx_q[0], e); end
      void'(rx_q.pop_front());
    end
    exp_byte_q.delete();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_lone();
    test_timeout();
    test_ext_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
